// File: rtl/parity_frame_checker.sv
// Checks per-nibble parity/all-ones flags over fixed-length frames and reports
// per-frame error count, all-ones count and frame parity through a valid/ready hold stage.
module parity_frame_checker #(
   parameter int unsigned FRAME_LEN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_data,
   input  logic       in_parity,
   input  logic       in_all_ones,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] out_err_cnt,
   output logic [3:0] out_ones_cnt,
   output logic       out_frame_parity,
   output logic       out_frame_err
);

   localparam logic [3:0] LastBeat = 4'(FRAME_LEN - 1);

   typedef enum logic {StAccum, StHold} state_e;

   state_e     r_state, w_state_d;
   logic [3:0] r_beat, w_beat_d;
   logic [3:0] r_err_acc, w_err_acc_d;
   logic [3:0] r_ones_acc, w_ones_acc_d;
   logic       r_par_acc, w_par_acc_d;
   logic [3:0] r_out_err, w_out_err_d;
   logic [3:0] r_out_ones, w_out_ones_d;
   logic       r_out_par, w_out_par_d;
   logic       r_out_ferr, w_out_ferr_d;

   logic       w_data_par;
   logic       w_data_ones;
   logic       w_mismatch;
   logic [3:0] w_err_sum;
   logic [3:0] w_ones_sum;
   logic       w_par_sum;

   assign w_data_par  = ^in_data;
   assign w_data_ones = &in_data;
   assign w_mismatch  = (in_parity != w_data_par) || (in_all_ones != w_data_ones);
   // Saturate rather than wrap so a long run of bad words never reads as clean.
   assign w_err_sum   = (r_err_acc == 4'hF) ? 4'hF : r_err_acc + {3'b000, w_mismatch};
   assign w_ones_sum  = r_ones_acc + {3'b000, w_data_ones};
   assign w_par_sum   = r_par_acc ^ w_data_par;

   always_comb begin
      w_state_d    = r_state;
      w_beat_d     = r_beat;
      w_err_acc_d  = r_err_acc;
      w_ones_acc_d = r_ones_acc;
      w_par_acc_d  = r_par_acc;
      w_out_err_d  = r_out_err;
      w_out_ones_d = r_out_ones;
      w_out_par_d  = r_out_par;
      w_out_ferr_d = r_out_ferr;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      unique case (r_state)
         StAccum: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (r_beat == LastBeat) begin
                  w_out_err_d  = w_err_sum;
                  w_out_ones_d = w_ones_sum;
                  w_out_par_d  = w_par_sum;
                  w_out_ferr_d = (w_err_sum != 4'h0);
                  w_err_acc_d  = 4'h0;
                  w_ones_acc_d = 4'h0;
                  w_par_acc_d  = 1'b0;
                  w_beat_d     = 4'h0;
                  w_state_d    = StHold;
               end else begin
                  w_err_acc_d  = w_err_sum;
                  w_ones_acc_d = w_ones_sum;
                  w_par_acc_d  = w_par_sum;
                  w_beat_d     = r_beat + 4'h1;
               end
            end
         end
         StHold: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_d = StAccum;
            end
         end
         default: w_state_d = StAccum;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StAccum;
         r_beat     <= 4'h0;
         r_err_acc  <= 4'h0;
         r_ones_acc <= 4'h0;
         r_par_acc  <= 1'b0;
         r_out_err  <= 4'h0;
         r_out_ones <= 4'h0;
         r_out_par  <= 1'b0;
         r_out_ferr <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_beat     <= w_beat_d;
         r_err_acc  <= w_err_acc_d;
         r_ones_acc <= w_ones_acc_d;
         r_par_acc  <= w_par_acc_d;
         r_out_err  <= w_out_err_d;
         r_out_ones <= w_out_ones_d;
         r_out_par  <= w_out_par_d;
         r_out_ferr <= w_out_ferr_d;
      end
   end

   assign out_err_cnt      = r_out_err;
   assign out_ones_cnt     = r_out_ones;
   assign out_frame_parity = r_out_par;
   assign out_frame_err    = r_out_ferr;

endmodule
